// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared types and constants for the uart block.
//
// Contents:
//   DEFAULT_CLK_FREQ, DEFAULT_BAUD : default line configuration
//   DATA_BITS, PARITY_BITS, FRAME_BITS : frame geometry
//   tx_state_t, rx_state_t : transmitter / receiver FSM encodings
//
// Optional feature macro: UART_PARITY_EN (even parity bit between the data
// bits and the stop bit, giving an 11-bit frame). Undefined by default.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    localparam int DATA_BITS = 8;
`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    // start + data + optional parity + stop
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- serial receiver: 2-FF synchroniser, receiver FSM, bit counter.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   rx     in   asynchronous serial line, idle high
//   data   out  assembled byte (valid when valid=1)
//   valid  out  one-cycle strobe: a byte with good stop (and parity) bit
//   state  out  current FSM state, for observation
//
// valid is combinational so that the parent can load its byte register and
// set its flag on the very edge that samples the stop bit.
//
// Optional feature macro: UART_PARITY_EN (even parity check).
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output rx_state_t  state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

    logic             rx_s1;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_PARITY_EN
    logic             par_err;
`endif

    // Synchroniser and previous-value register run every cycle; rx_prev
    // gives the falling-edge detect used in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                    end
                end

                // Re-check the line half a bit in; a high line here was a glitch.
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_PARITY_EN
                        par_err <= 1'b0;
`endif
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // LSB first: shift in from the top.
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_err <= rx_sync ^ (^shift);
                        state   <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                // A low stop bit means a framing error: wait for the line to
                // return high before looking for the next start edge.
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RX_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_sync) begin
                        state <= RX_IDLE;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign data = shift;

`ifdef UART_PARITY_EN
    assign valid = (state == RX_STOP) && (cnt == BIT_LAST) && rx_sync && !par_err;
`else
    assign valid = (state == RX_STOP) && (cnt == BIT_LAST) && rx_sync;
`endif

endmodule

// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart -- full-duplex 8-bit UART with a byte-level trigger handshake.
//
// Ports:
//   CLK_50MHZ    in   system clock, rising edge
//   RST          in   synchronous active-low reset
//   RX           in   serial input, asynchronous, idle high
//   TX           out  serial output, idle high
//   FLOW         in   1 = remote not ready; holds a pending write in IDLE
//   DATA_IN      in   byte to transmit, captured on a TRG_WRITE rising edge
//   DATA_OUT     out  last byte received without error
//   TRG_READ     in   read acknowledge, rising-edge sensitive (clears DONE)
//   TRG_WRITE    in   write request, rising-edge sensitive
//   DONE         out  received byte available
//   dbg_tx_state out  transmitter FSM state, for observation
//   dbg_rx_state out  receiver FSM state, for observation
//
// Handshake: a TRG_WRITE rising edge is accepted only while the transmitter
// is IDLE with nothing pending; the frame starts on the following edge once
// FLOW=0. DONE rises with DATA_OUT on a good byte and falls on the edge that
// samples a TRG_READ rising edge; a simultaneous new byte keeps DONE high.
//
// Optional feature macro: UART_PARITY_EN (even parity, 11-bit frame).
// ---------------------------------------------------------------------------
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD   // minimum 4
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       RX,
    output logic       TX,
    input  logic       FLOW,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    input  logic       TRG_READ,
    input  logic       TRG_WRITE,
    output logic       DONE,
    output tx_state_t  dbg_tx_state,
    output rx_state_t  dbg_rx_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    // Trigger edge detect: the registered copy is the previous value.
    logic trg_read_q;
    logic trg_write_q;
    logic read_edge;
    logic write_edge;

    assign read_edge  = TRG_READ  && !trg_read_q;
    assign write_edge = TRG_WRITE && !trg_write_q;

    // ---------------- transmitter ----------------
    tx_state_t        tx_state;
    logic             tx_reg;
    logic             pending;
    logic [7:0]       tx_shift;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
`ifdef UART_PARITY_EN
    logic             tx_par;
`endif

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            trg_write_q <= 1'b0;
            tx_state    <= TX_IDLE;
            tx_reg      <= 1'b1;
            pending     <= 1'b0;
            tx_shift    <= '0;
            tx_cnt      <= '0;
            tx_idx      <= '0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            trg_write_q <= TRG_WRITE;
            case (tx_state)
                // FLOW is only consulted here; once a frame starts it completes.
                TX_IDLE: begin
                    tx_reg <= 1'b1;
                    tx_cnt <= '0;
                    if (pending && !FLOW) begin
                        pending  <= 1'b0;
                        tx_reg   <= 1'b0;
                        tx_state <= TX_START;
                    end else if (write_edge && !pending) begin
                        tx_shift <= DATA_IN;
                        pending  <= 1'b1;
`ifdef UART_PARITY_EN
                        tx_par   <= ^DATA_IN;
`endif
                    end
                end

                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_reg   <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end

                // The shift register moves right so bit 0 is always on the line
                // and bit 1 is the next one out.
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                            tx_reg   <= tx_par;
                            tx_state <= TX_PARITY;
`else
                            tx_reg   <= 1'b1;
                            tx_state <= TX_STOP;
`endif
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            tx_reg   <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end

`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_reg   <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif

                TX_STOP: begin
                    tx_reg <= 1'b1;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end

                default: begin
                    tx_reg   <= 1'b1;
                    tx_cnt   <= '0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign TX           = tx_reg;
    assign dbg_tx_state = tx_state;

    // ---------------- receiver ----------------
    logic [7:0] rx_data;
    logic       rx_valid;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk   (CLK_50MHZ),
        .rst_n (RST),
        .rx    (RX),
        .data  (rx_data),
        .valid (rx_valid),
        .state (dbg_rx_state)
    );

    // ---------------- DONE / DATA_OUT ----------------
    logic [7:0] data_out_reg;
    logic       done_reg;

    // A new byte takes priority over a simultaneous read acknowledge, and
    // overwrites an unread byte (overrun keeps DONE high).
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            trg_read_q   <= 1'b0;
            data_out_reg <= 8'h00;
            done_reg     <= 1'b0;
        end else begin
            trg_read_q <= TRG_READ;
            if (rx_valid) begin
                data_out_reg <= rx_data;
                done_reg     <= 1'b1;
            end else if (read_edge) begin
                done_reg <= 1'b0;
            end
        end
    end

    assign DATA_OUT = data_out_reg;
    assign DONE     = done_reg;

endmodule

// File: tb/tb_uart.sv
// ---------------------------------------------------------------------------
// tb_uart -- self-checking bench for uart with CLKS_PER_BIT = 8.
// Inputs change on the falling clock edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_uart;
    import uart_pkg::*;

    localparam int CPB = 8;

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_drv;
    logic       loop_en;
    logic       rx_line;
    logic       tx;
    logic       flow;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       trg_read;
    logic       trg_write;
    logic       done;
    tx_state_t  dbg_tx;
    rx_state_t  dbg_rx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx : rx_drv;

    uart #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK_50MHZ    (clk),
        .RST          (rst),
        .RX           (rx_line),
        .TX           (tx),
        .FLOW         (flow),
        .DATA_IN      (data_in),
        .DATA_OUT     (data_out),
        .TRG_READ     (trg_read),
        .TRG_WRITE    (trg_write),
        .DONE         (done),
        .dbg_tx_state (dbg_tx),
        .dbg_rx_state (dbg_rx)
    );

    // ---------------- scoreboard / check ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Line frame, bit 0 first on the wire.
    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b, input logic stop);
        logic [FRAME_BITS-1:0] f;
        f      = '0;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_PARITY_EN
        f[9]   = ^b;
`endif
        f[FRAME_BITS-1] = stop;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [FRAME_BITS-1:0] f;
        f = frame_of(b, stop);
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    // Called on the first cycle of the start bit; checks every cycle of the frame.
    task automatic check_tx_frame(input logic [7:0] b, input string name);
        logic [FRAME_BITS-1:0] f;
        logic got;
        f = frame_of(b, 1'b1);
        for (int i = 0; i < FRAME_BITS; i++) begin
            got = f[i];
            for (int c = 0; c < CPB; c++) begin
                if (tx !== f[i]) got = tx;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", name, i), 32'(got), 32'(f[i]));
        end
    endtask

    task automatic read_pulse(input string name);
        trg_read = 1'b1;
        @(negedge clk);
        check(name, 32'(done), 32'd0);
        trg_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- table of RX vectors ----------------
    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        logic       exp_done;
        logic [7:0] exp_data;
    } rx_vec_t;

    rx_vec_t vecs[5];

    int         lat;
    int         cyc;
    logic       stuck;
    logic [7:0] b;
    logic [7:0] exp_b;

    initial begin
        // Framing errors must leave DATA_OUT at the last good byte.
        vecs[0] = '{8'h55, 1'b0, 1'b0, 8'h3C};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81};

        rst       = 1'b0;
        rx_drv    = 1'b1;
        loop_en   = 1'b0;
        flow      = 1'b0;
        data_in   = 8'h00;
        trg_read  = 1'b0;
        trg_write = 1'b0;

        // ---- reset ----
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data_out", 32'(data_out), 32'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---- TX 8'hA5, trigger held high afterwards ----
        data_in   = 8'hA5;
        trg_write = 1'b1;
        @(negedge clk);
        check("tx_a5_idle_at_trigger", 32'(tx), 32'd1);
        @(negedge clk);
        check_tx_frame(8'hA5, "tx_a5");
        stuck = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (tx !== 1'b1) stuck = tx;
            @(negedge clk);
        end
        check("tx_held_trigger_no_second_frame", 32'(stuck), 32'd1);
        trg_write = 1'b0;
        repeat (4) @(negedge clk);

        // ---- RX 8'h3C with latency check ----
        fork
            send_rx(8'h3C, 1'b1);
            begin
                lat = 0;
                while (!done && lat < 200) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end
            end
        join
        check("rx_3c_latency_in_window", 32'((lat >= 77) && (lat <= 79)), 32'd1);
        if (!((lat >= 77) && (lat <= 79))) $display("  latency was %0d cycles", lat);
        repeat (2) @(negedge clk);
        check("rx_3c_done", 32'(done), 32'd1);
        check("rx_3c_data", 32'(data_out), 32'h3C);
        read_pulse("rx_3c_read_clears_done");
        repeat (2 * CPB) @(negedge clk);

        // ---- table-driven RX vectors ----
        for (int i = 0; i < 5; i++) begin
            send_rx(vecs[i].byte_v, vecs[i].stop_v);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
            if (vecs[i].exp_done) read_pulse($sformatf("vec%0d_read_clears", i));
            repeat (2 * CPB) @(negedge clk);
        end

        // ---- glitch: RX low for 2 cycles ----
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        stuck = 1'b0;
        for (int c = 0; c < 12 * CPB; c++) begin
            if (done !== 1'b0) stuck = 1'b1;
            @(negedge clk);
        end
        check("glitch_no_done", 32'(stuck), 32'd0);
        check("glitch_rx_idle", 32'(dbg_rx), 32'(RX_IDLE));

        // ---- FLOW hold ----
        flow      = 1'b1;
        data_in   = 8'h81;
        trg_write = 1'b1;
        @(negedge clk);
        trg_write = 1'b0;
        stuck = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (tx !== 1'b1) stuck = tx;
            @(negedge clk);
        end
        check("flow_holds_tx_high", 32'(stuck), 32'd1);
        flow = 1'b0;
        @(negedge clk);
        check_tx_frame(8'h81, "tx_flow_81");
        repeat (4) @(negedge clk);

        // ---- loopback, 6 random bytes ----
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        data_in   = b;
        trg_write = 1'b1;
        @(negedge clk);
        trg_write = 1'b0;
        for (int n = 0; n < 6; n++) begin
            wait_done(300, cyc);
            check($sformatf("lb%0d_done", n), 32'(done), 32'd1);
            exp_b = exp_q.pop_front();
            check($sformatf("lb%0d_data", n), 32'(data_out), 32'(exp_b));
            // The transmitter leaves STOP just after DONE; wait for IDLE.
            repeat (2) @(negedge clk);
            if (n < 5) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                data_in   = b;
                trg_write = 1'b1;
            end
            trg_read = 1'b1;
            @(negedge clk);
            check($sformatf("lb%0d_read_clears", n), 32'(done), 32'd0);
            trg_read  = 1'b0;
            trg_write = 1'b0;
        end
        check("lb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
